// File: rtl/icache.sv
// Direct-mapped instruction cache with one-cycle registered response and single-line refill
// over a req/gnt + rvalid memory handshake.
module icache #(
  parameter int unsigned LINES      = 64,
  parameter int unsigned LINE_WORDS = 4,
  parameter logic [31:0] IMEM_LIMIT = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_addr,
  input  logic        i_rd,
  input  logic        flush,
  output logic [31:0] i_data,
  output logic        i_miss,
  output logic        i_segfault,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid
);

  localparam int unsigned OW = $clog2(LINE_WORDS);
  localparam int unsigned IW = $clog2(LINES);
  localparam int unsigned TW = 32 - IW - OW - 2;

  typedef enum logic [1:0] {StIdle, StReq, StFill} state_e;

  state_e            state_q, state_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic [TW-1:0]     tag_q  [LINES];
  logic [31:0]       data_q [LINES][LINE_WORDS];
  logic [OW-1:0]     cnt_q, cnt_d;
  logic              drop_q, drop_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic              mem_req_q, mem_req_d;
  logic [31:0]       i_data_q, i_data_d;
  logic              i_miss_q, i_miss_d;
  logic              i_seg_q, i_seg_d;

  logic [OW-1:0] off;
  logic [IW-1:0] idx, fill_idx;
  logic [TW-1:0] tag, fill_tag;
  logic          seg, hit, start, fill_we, last;

  assign off      = i_addr[OW+1:2];
  assign idx      = i_addr[IW+OW+1:OW+2];
  assign tag      = i_addr[31:IW+OW+2];
  // The in-flight line is identified by the latched refill address.
  assign fill_idx = mem_addr_q[IW+OW+1:OW+2];
  assign fill_tag = mem_addr_q[31:IW+OW+2];

  assign seg     = (i_addr >= IMEM_LIMIT) || (i_addr[1:0] != 2'b00);
  assign hit     = (state_q == StIdle) && valid_q[idx] && (tag_q[idx] == tag);
  assign start   = i_rd && !seg && !hit && (state_q == StIdle);
  assign fill_we = (state_q == StFill) && mem_rvalid;
  assign last    = fill_we && (cnt_q == OW'(LINE_WORDS - 1));

  always_comb begin
    i_data_d   = '0;
    i_miss_d   = 1'b0;
    i_seg_d    = 1'b0;
    mem_addr_d = mem_addr_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    drop_d     = drop_q;
    valid_d    = valid_q;

    if (i_rd) begin
      if (seg) begin
        i_seg_d = 1'b1;
      end else if (hit) begin
        i_data_d = data_q[idx][off];
      end else begin
        i_miss_d = 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StReq;
          mem_addr_d = {i_addr[31:OW+2], {(OW + 2){1'b0}}};
          valid_d[idx] = 1'b0;
        end
      end
      StReq: begin
        if (mem_gnt) state_d = StFill;
      end
      StFill: begin
        if (fill_we) cnt_d = cnt_q + 1'b1;
        if (last) begin
          state_d = StIdle;
          if (!drop_q) valid_d[fill_idx] = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (flush && (state_q != StIdle)) drop_d = 1'b1;
    if (last) drop_d = 1'b0;
    if (flush) valid_d = '0;

    mem_req_d = (state_d == StReq);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      valid_q    <= '0;
      cnt_q      <= '0;
      drop_q     <= 1'b0;
      mem_addr_q <= '0;
      mem_req_q  <= 1'b0;
      i_data_q   <= '0;
      i_miss_q   <= 1'b0;
      i_seg_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      cnt_q      <= cnt_d;
      drop_q     <= drop_d;
      mem_addr_q <= mem_addr_d;
      mem_req_q  <= mem_req_d;
      i_data_q   <= i_data_d;
      i_miss_q   <= i_miss_d;
      i_seg_q    <= i_seg_d;
    end
  end

  // Line storage needs no reset; valid bits guard every read.
  always_ff @(posedge clk) begin
    if (fill_we) data_q[fill_idx][cnt_q] <= mem_rdata;
    if (last)    tag_q[fill_idx]         <= fill_tag;
  end

  assign i_data     = i_data_q;
  assign i_miss     = i_miss_q;
  assign i_segfault = i_seg_q;
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;

endmodule
